// File: rtl/boreal_host_pkg.sv
// -----------------------------------------------------------------------------
// boreal_host_pkg
// Shared constants for the Boreal host loader: frame opcodes, response bytes,
// the parser state encoding and a small helper that tells which parser states
// are allowed to take bytes from the UART receiver.
// -----------------------------------------------------------------------------
package boreal_host_pkg;

    // Frame opcodes (first byte of every frame)
    localparam logic [7:0] OP_WRITE = 8'hA5;
    localparam logic [7:0] OP_READ  = 8'h5A;

    // Single-byte responses
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    // Parser states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR       = 3'd1,
        DATA       = 3'd2,
        WRITE      = 3'd3,
        READ_ISSUE = 3'd4,
        READ_CAP   = 3'd5,
        RESP       = 3'd6
    } state_e;

    // True for the states in which the receiver side may hand over a byte
    function automatic logic rx_open(input logic [2:0] st);
        rx_open = (st == 3'(IDLE)) || (st == 3'(ADDR)) || (st == 3'(DATA));
    endfunction

endpackage

// File: rtl/boreal_host_loader_if.sv
// -----------------------------------------------------------------------------
// boreal_host_loader_if
// Bundles the three byte/word channels around the host loader:
//   rx_*   : command bytes from the UART receiver (valid/ready)
//   tx_*   : response bytes to the UART transmitter (valid/ready)
//   *_b    : host port of the weight/LUT memory (registered read data)
// Modports:
//   master : the loader (drives rx_ready, tx_*, we_b, addr_b, din_b)
//   slave  : the surroundings (UART + memory)
// -----------------------------------------------------------------------------
interface boreal_host_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) ();
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_b;

    modport master (
        input  rx_data, rx_valid, tx_ready, dout_b,
        output rx_ready, tx_data, tx_valid, we_b, addr_b, din_b
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dout_b,
        input  rx_ready, tx_data, tx_valid, we_b, addr_b, din_b
    );
endinterface

// File: rtl/boreal_byte_timer.sv
// -----------------------------------------------------------------------------
// boreal_byte_timer
// Inter-byte timeout counter for frames in progress.
//   clk, rst   : clock, synchronous active-high reset
//   i_en       : a frame is being received (counting allowed)
//   i_clr      : a byte was accepted this cycle (restart the count)
//   o_expired  : single-cycle pulse in the cycle whose closing edge brings
//                the count to TIMEOUT_CYCLES, so the parser aborts on that
//                same edge
// The count saturates at TIMEOUT_CYCLES and returns to zero whenever the
// timer is disabled.
// -----------------------------------------------------------------------------
module boreal_byte_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Expire when the next idle increment would reach the limit
    assign o_expired = i_en && !i_clr && (r_count == LAST);

    // Idle-cycle counter with clear on accepted byte and saturation at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr || !i_en) begin
            r_count <= '0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end
endmodule

// File: rtl/boreal_host_loader.sv
// -----------------------------------------------------------------------------
// boreal_host_loader
// Byte-stream command engine on the host port of the Boreal weight/LUT memory.
// Parses write frames (A5, ADDR_HI, ADDR_LO, NB data bytes, MSB first) and
// read frames (5A, ADDR_HI, ADDR_LO), performs the memory access and returns
// ACK (06), NAK (15) or the NB read-data bytes MSB first.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : master side of boreal_host_loader_if (rx, tx, memory port)
//   busy       : parser is not in IDLE
//   frame_err  : one-cycle pulse when an inter-byte timeout drops a frame
// All outputs are registered.
// -----------------------------------------------------------------------------
module boreal_host_loader
    import boreal_host_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    boreal_host_loader_if.master bus,
    output logic                 busy,
    output logic                 frame_err
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int DCNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(NB - 1);

    localparam logic [2:0] S_IDLE       = IDLE;
    localparam logic [2:0] S_ADDR       = ADDR;
    localparam logic [2:0] S_DATA       = DATA;
    localparam logic [2:0] S_WRITE      = WRITE;
    localparam logic [2:0] S_READ_ISSUE = READ_ISSUE;
    localparam logic [2:0] S_READ_CAP   = READ_CAP;
    localparam logic [2:0] S_RESP       = RESP;

    // Parser state and assembly registers
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  r_is_write;
    logic                  r_addr_cnt;     // 0: next byte is ADDR_HI, 1: ADDR_LO
    logic [7:0]            r_addr_hi;
    logic [ADDR_WIDTH-1:0] r_addr_asm;
    logic [DCNT_W-1:0]     r_data_cnt;
    logic [DATA_WIDTH-1:0] r_data_asm;
    logic [DATA_WIDTH-1:0] r_resp_sr;      // bytes still to send after r_tx_data
    logic [DCNT_W-1:0]     r_resp_cnt;     // how many bytes remain after r_tx_data

    // Registered outputs
    logic                  r_rx_ready;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_we_b;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [DATA_WIDTH-1:0] r_din_b;
    logic                  r_busy;
    logic                  r_frame_err;

    // Handshakes and derived words
    logic                  w_rx_fire;
    logic                  w_tx_fire;
    logic                  w_in_frame;
    logic                  w_expired;
    logic                  w_op_valid;
    logic [ADDR_WIDTH-1:0] w_addr_trunc;
    logic [DATA_WIDTH-1:0] w_data_nxt;

    assign w_rx_fire    = r_rx_ready && bus.rx_valid;
    assign w_tx_fire    = r_tx_valid && bus.tx_ready;
    assign w_in_frame   = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_op_valid   = (bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ);
    // 16-bit wire address truncated to the memory width
    assign w_addr_trunc = ADDR_WIDTH'({r_addr_hi, bus.rx_data});
    // Data word shifted one byte left with the new byte in the LSBs
    assign w_data_nxt   = DATA_WIDTH'({r_data_asm, bus.rx_data});

    assign bus.rx_ready = r_rx_ready;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.we_b     = r_we_b;
    assign bus.addr_b   = r_addr_b;
    assign bus.din_b    = r_din_b;
    assign busy         = r_busy;
    assign frame_err    = r_frame_err;

    boreal_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_rx_fire),
        .i_en      (w_in_frame),
        .o_expired (w_expired)
    );

    // Parser next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    w_state_nxt = w_op_valid ? S_ADDR : S_RESP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR: begin
                if (w_expired) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rx_fire && r_addr_cnt) begin
                    w_state_nxt = r_is_write ? S_DATA : S_READ_ISSUE;
                end else begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_DATA: begin
                if (w_expired) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rx_fire && (r_data_cnt == DCNT_LAST)) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_WRITE:      w_state_nxt = S_RESP;
            S_READ_ISSUE: w_state_nxt = S_READ_CAP;
            S_READ_CAP:   w_state_nxt = S_RESP;
            S_RESP: begin
                if (w_tx_fire && (r_resp_cnt == '0)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // State, assembly registers, memory port and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_write  <= 1'b0;
            r_addr_cnt  <= 1'b0;
            r_addr_hi   <= 8'h00;
            r_addr_asm  <= '0;
            r_data_cnt  <= '0;
            r_data_asm  <= '0;
            r_resp_sr   <= '0;
            r_resp_cnt  <= '0;
            r_rx_ready  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_we_b      <= 1'b0;
            r_addr_b    <= '0;
            r_din_b     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // rx_ready and busy follow the state being entered
            r_rx_ready  <= rx_open(w_state_nxt);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_frame_err <= w_expired;
            r_we_b      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        r_is_write <= (bus.rx_data == OP_WRITE);
                        r_addr_cnt <= 1'b0;
                        r_data_cnt <= '0;
                        if (!w_op_valid) begin
                            r_tx_data  <= RSP_NAK;
                            r_tx_valid <= 1'b1;
                            r_resp_cnt <= '0;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        if (!r_addr_cnt) begin
                            r_addr_hi  <= bus.rx_data;
                            r_addr_cnt <= 1'b1;
                        end else begin
                            r_addr_asm <= w_addr_trunc;
                            // A read drives the address straight into READ_ISSUE
                            if (!r_is_write) begin
                                r_addr_b <= w_addr_trunc;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_data_asm <= w_data_nxt;
                        r_data_cnt <= r_data_cnt + DCNT_W'(1);
                        // Last byte: present the full word for the single WRITE cycle
                        if (r_data_cnt == DCNT_LAST) begin
                            r_we_b   <= 1'b1;
                            r_addr_b <= r_addr_asm;
                            r_din_b  <= w_data_nxt;
                        end
                    end
                end
                S_WRITE: begin
                    r_tx_data  <= RSP_ACK;
                    r_tx_valid <= 1'b1;
                    r_resp_cnt <= '0;
                end
                S_READ_ISSUE: begin
                    r_resp_cnt <= '0;
                end
                S_READ_CAP: begin
                    // Memory data is valid now (one cycle after addr_b)
                    r_tx_data  <= bus.dout_b[DATA_WIDTH-1 -: 8];
                    r_resp_sr  <= bus.dout_b << 8;
                    r_tx_valid <= 1'b1;
                    r_resp_cnt <= DCNT_LAST;
                end
                S_RESP: begin
                    if (w_tx_fire) begin
                        if (r_resp_cnt == '0) begin
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_tx_data  <= r_resp_sr[DATA_WIDTH-1 -: 8];
                            r_resp_sr  <= r_resp_sr << 8;
                            r_resp_cnt <= r_resp_cnt - DCNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/boreal_host_loader.md
# boreal_host_loader

Byte-stream command engine that owns the learning/host port of the Boreal Neuro-Core weight/LUT memory. It parses write and read frames arriving from the UART receiver, drives the memory's write port (`we_b`/`addr_b`/`din_b`) and samples its registered read data (`dout_b`). It returns acknowledge bytes or read-data bytes to the UART transmitter. It sits between the UART byte interfaces and the dual-port memory; inference traffic on the other memory port is unaffected.

## Interface
- `ADDR_WIDTH`, 10: memory address width; must be ≤ 16.
- `DATA_WIDTH`, 32: memory word width; must be a multiple of 8. `NB = DATA_WIDTH/8` bytes per word.
- `TIMEOUT_CYCLES`, 100000: maximum idle cycles allowed between bytes inside a frame.
- `clk`  in  1  sole clock; all logic samples on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  command byte from the UART receiver.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `tx_data`  out  8  response byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts a byte this cycle.
- `we_b`  out  1  memory write enable.
- `addr_b`  out  ADDR_WIDTH  memory address.
- `din_b`  out  DATA_WIDTH  memory write data.
- `dout_b`  in  DATA_WIDTH  memory read data; registered, 1-cycle latency from `addr_b`.
- `busy`  out  1  high in any state other than IDLE.
- `frame_err`  out  1  one-cycle pulse when an inter-byte timeout aborts a frame.

## Operation
- **Frames.** All multi-byte fields are sent MSB first.
  - Write: `0xA5`, ADDR_HI, ADDR_LO, then NB data bytes.
  - Read: `0x5A`, ADDR_HI, ADDR_LO.
- **Address.** The 16-bit address is truncated to its low ADDR_WIDTH bits.
- **Byte transfer.** A byte is accepted when `rx_valid && rx_ready`. A response byte is transferred when `tx_valid && tx_ready`.
- **States.** IDLE → ADDR (2 bytes) → DATA (NB bytes, write frames only) → WRITE or READ_ISSUE → READ_CAP → RESP → IDLE.
  - IDLE: an opcode byte other than `0xA5` or `0x5A` loads NAK `0x15` and goes to RESP.
  - WRITE: `we_b` = 1 for exactly one cycle, with `addr_b`/`din_b` valid. Then ACK `0x06` is loaded and the block goes to RESP.
  - READ_ISSUE: drives `addr_b` for one cycle.
  - READ_CAP: latches `dout_b` into the response shift register. RESP then sends NB bytes, MSB first.
  - RESP: after the last byte is transferred, the next state is IDLE.
- **`rx_ready`.** High only in IDLE, ADDR and DATA. Low in WRITE, READ_ISSUE, READ_CAP, RESP and during reset.
- **Timeout.** In ADDR and DATA, a counter clears on every accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: pulse `frame_err`, discard the frame, go to IDLE.
  - No response is sent and no write occurs.
  - RESP never times out; indefinite `tx_ready` backpressure is legal.
- **Register holding.** `addr_b` and `din_b` hold their last values between frames. `we_b` is asserted at no other time.
- **Reset values.** `rx_ready` 0, `tx_valid` 0, `tx_data` 0, `we_b` 0, `addr_b` 0, `din_b` 0, `busy` 0, `frame_err` 0, state IDLE, timeout counter 0.
  - `rx_ready` rises in the first cycle after `rst` deasserts.
  - Reset mid-frame or mid-response discards all partial state. No write and no further tx bytes are produced.

## Timing
- **Write.** Last data byte accepted in cycle T:
  - `we_b` high in T+1.
  - ACK `tx_valid` first high in T+2.
- **Read.** Last address byte accepted in cycle T:
  - T+1: READ_ISSUE, `addr_b` valid.
  - T+2: READ_CAP.
  - T+3: first `tx_valid`, MSB byte.
- **NAK.** Bad opcode accepted in T → `tx_valid` high in T+1.
- **TX stability.** `tx_data` stays stable while `tx_valid && !tx_ready`. `tx_valid` stays high until the transfer completes.
- **Back-to-back frames.** After the last response transfer in cycle T, the state is IDLE in T+1 with `rx_ready` = 1.
- **Throughput.** One byte per cycle on both rx and tx.
- **Width rules.**
  - The ADDR byte counter is 1 bit; the DATA byte counter is `$clog2(NB)` bits.
  - The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates at the abort.

## Structure
- **Package `boreal_host_pkg`:**
  - Opcodes `OP_WRITE = 8'hA5` and `OP_READ = 8'h5A`.
  - Response bytes `RSP_ACK = 8'h06` and `RSP_NAK = 8'h15`.
  - State enum IDLE, ADDR, DATA, WRITE, READ_ISSUE, READ_CAP, RESP.
- **Sub-module `boreal_byte_timer`:** the inter-byte timeout counter, with inputs clear/enable and output expired pulse.
- **Main module:** the parser FSM, the address/data assembly registers and the response shift register stay in the main module.

## Test plan
Bench uses `boreal_memory` as the memory model and TIMEOUT_CYCLES = 16.

- **Write.** Send `A5 FC 05 DE AD BE EF` → `we_b` one cycle, `addr_b` = `0x005`, `din_b` = `0xDEADBEEF`, then `tx_data` `0x06`.
- **Readback.** Send `5A 00 05` → `tx_data` = DE, AD, BE, EF in order, first `tx_valid` 3 cycles after the last address byte, `we_b` never high.
- **Bad opcode.** Send `0x33` → `tx_data` `0x15` next cycle, no `we_b`. A following write frame completes normally.
- **Timeout.** Send `A5 01`, then idle 16 cycles → `frame_err` pulses once, no tx byte, no `we_b`. A following read of address `0x005` returns `0xDEADBEEF`.
- **Backpressure.** Read with `tx_ready` toggling every cycle → `rx_ready` low throughout the response, `tx_data` stable while stalled, 4 bytes delivered in order.
- **Reset mid-frame.** Send `A5 01 23 11`, assert `rst` for one cycle → all outputs at reset values, no `we_b`. Then send `A5 01 23 01 02 03 04` → memory[0x123] = `0x01020304`, ACK returned.
